// File: rtl/s641_cap_pkg.sv
// Shared definitions for the s641 response-capture stage.
//   W      : response / signature width (one bit per s641 primary output)
//   POLY   : Galois feedback taps, x^24+x^23+x^22+x^17+1 with x^24 implicit
//   SEED   : signature value after reset and at every accepted start
//   CNT_W  : width of the vector counter and the num_cycles request
//   cap_state_t : capture FSM states
package s641_cap_pkg;

  localparam int          W     = 24;
  localparam logic [23:0] POLY  = 24'hC20001;
  localparam logic [23:0] SEED  = 24'h000000;
  localparam int          CNT_W = 16;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RUN  = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/misr_step.sv
// One MISR update: shift the signature left, fold the outgoing MSB back
// through the feedback taps, then XOR in the new response vector.
// Purely combinational, so it can also drive an LFSR stimulus generator
// (tie resp to zero).
//   sig   in  W : current signature
//   resp  in  W : response vector to fold in
//   sig_n out W : next signature
module misr_step
  import s641_cap_pkg::*;
(
  input  logic [W-1:0] sig,
  input  logic [W-1:0] resp,
  output logic [W-1:0] sig_n
);

  assign sig_n = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ resp;

endmodule

// File: rtl/s641_resp_compactor.sv
// Response-capture stage for s641: folds a programmed number of 24-bit
// response vectors into a MISR signature and compares the result with a
// golden value, reducing a whole test run to one pass bit.
//   CK          in  1     : clock, rising edge
//   RST         in  1     : asynchronous active-high reset
//   start       in  1     : begin a run (honoured in IDLE or DONE only)
//   num_cycles  in  CNT_W : vectors to compact, captured on the start edge
//   resp        in  W     : s641 output vector
//   resp_valid  in  1     : resp carries a real vector this cycle
//   golden      in  W     : expected final signature
//   sig         out W     : current signature
//   busy        out 1     : run in progress
//   done        out 1     : run finished, sig final
//   vec_cnt     out CNT_W : vectors accepted in the current/last run
//   pass        out 1     : done and sig matches golden
module s641_resp_compactor
  import s641_cap_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [W-1:0]     resp,
  input  logic             resp_valid,
  input  logic [W-1:0]     golden,
  output logic [W-1:0]     sig,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             pass
);

  cap_state_t       state, state_n;
  logic [W-1:0]     sig_step, sig_n;
  logic [CNT_W-1:0] cnt_n, tgt, tgt_n;

  misr_step u_step (
    .sig   (sig),
    .resp  (resp),
    .sig_n (sig_step)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state   <= CAP_IDLE;
      sig     <= SEED;
      vec_cnt <= '0;
      tgt     <= '0;
    end else begin
      state   <= state_n;
      sig     <= sig_n;
      vec_cnt <= cnt_n;
      tgt     <= tgt_n;
    end
  end

  always_comb begin
    state_n = state;
    sig_n   = sig;
    cnt_n   = vec_cnt;
    tgt_n   = tgt;
    case (state)
      // A restart from DONE behaves exactly like a start from IDLE; the
      // vector present on the start edge itself is never compacted.
      CAP_IDLE, CAP_DONE: begin
        if (start) begin
          sig_n   = SEED;
          cnt_n   = '0;
          tgt_n   = num_cycles;
          state_n = (num_cycles == '0) ? CAP_DONE : CAP_RUN;
        end
      end
      CAP_RUN: begin
        if (resp_valid) begin
          sig_n = sig_step;
          cnt_n = vec_cnt + CNT_W'(1);
          // tgt is never zero in RUN, so the counter stops before wrapping.
          if (cnt_n == tgt) state_n = CAP_DONE;
        end
      end
      default: state_n = CAP_IDLE;
    endcase
  end

  assign busy = (state == CAP_RUN);
  assign done = (state == CAP_DONE);
  assign pass = done & (sig == golden);

endmodule

// File: tb/tb_s641_resp_compactor.sv
module tb_s641_resp_compactor;
  import s641_cap_pkg::*;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_cycles = '0;
  logic [23:0] resp = '0;
  logic        resp_valid = 1'b0;
  logic [23:0] golden = '0;
  logic [23:0] sig;
  logic        busy, done, pass;
  logic [15:0] vec_cnt;

  int total = 0;
  int bad = 0;

  s641_resp_compactor dut (
    .CK(CK), .RST(RST), .start(start), .num_cycles(num_cycles),
    .resp(resp), .resp_valid(resp_valid), .golden(golden),
    .sig(sig), .busy(busy), .done(done), .vec_cnt(vec_cnt), .pass(pass)
  );

  always #5 CK = ~CK;

  // Polynomial view: multiply by x, reduce modulo the full degree-24
  // polynomial, add the response.
  function automatic logic [23:0] ref_step(input logic [23:0] s, input logic [23:0] r);
    logic [24:0] x;
    x = {s, 1'b0};
    if (x[24]) x = x ^ 25'h1C20001;
    return x[23:0] ^ r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: run bookkeeping in plain variables.
  logic [23:0] m_sig;
  int          m_cnt, m_tgt;
  bit          m_running, m_finished;

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_sig = SEED; m_cnt = 0; m_tgt = 0; m_running = 0; m_finished = 0;
    end else if (!m_running && start) begin
      m_sig = SEED; m_cnt = 0; m_tgt = int'(num_cycles);
      m_running = (num_cycles != 0);
      m_finished = (num_cycles == 0);
    end else if (m_running && resp_valid) begin
      m_sig = ref_step(m_sig, resp);
      m_cnt++;
      if (m_cnt == m_tgt) begin m_running = 0; m_finished = 1; end
    end
  end

  always @(posedge CK) begin
    #2;
    if (!RST) begin
      chk("m_sig", 32'(sig), 32'(m_sig));
      chk("m_cnt", 32'(vec_cnt), 32'(m_cnt));
      chk("m_busy", 32'(busy), 32'(m_running));
      chk("m_done", 32'(done), 32'(m_finished));
      chk("m_pass", 32'(pass), 32'(m_finished && (m_sig == golden)));
    end
  end

  // Drive one cycle: inputs change on the falling edge, return on the next.
  task automatic cyc(input logic s, input logic [15:0] n, input logic v, input logic [23:0] r);
    start = s; num_cycles = n; resp_valid = v; resp = r;
    @(negedge CK);
  endtask

  int acc;
  int busy_cycles;

  initial begin
    @(negedge CK); @(negedge CK);
    chk("rst_sig", 32'(sig), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    RST = 1'b0;
    @(negedge CK);

    // Single vector; the vector on the start edge must be ignored.
    cyc(1, 1, 1, 24'hFFFFFF);
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_sig0", 32'(sig), 32'h0);
    cyc(0, 0, 1, 24'h000001);
    chk("t2_sig", 32'(sig), 32'h000001);
    chk("t2_cnt", 32'(vec_cnt), 32'h1);
    chk("t2_done", 32'(done), 32'h1);
    golden = 24'h000001; #1;
    chk("t2_pass1", 32'(pass), 32'h1);
    golden = 24'h000002; #1;
    chk("t2_pass0", 32'(pass), 32'h0);
    golden = 24'h0;
    cyc(0, 0, 0, 0);

    // Feedback through the taps.
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 24'h800000);
    chk("t3_sig1", 32'(sig), 32'h800000);
    chk("t3_done1", 32'(done), 32'h0);
    cyc(0, 0, 1, 24'h000000);
    chk("t3_sig", 32'(sig), 32'hC20001);
    chk("t3_done", 32'(done), 32'h1);

    // Stall in the middle of a run.
    busy_cycles = 0;
    cyc(1, 2, 0, 0);
    if (busy) busy_cycles++;
    cyc(0, 0, 1, 24'h000001);
    if (busy) busy_cycles++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 24'h555555);
      chk("t4_stall_cnt", 32'(vec_cnt), 32'h1);
      if (busy) busy_cycles++;
    end
    cyc(0, 0, 1, 24'h000000);
    if (busy) busy_cycles++;
    chk("t4_sig", 32'(sig), 32'h000002);
    chk("t4_busy_len", 32'(busy_cycles), 32'd5);
    chk("t4_done", 32'(done), 32'h1);

    // Zero-length run, ignored start in RUN, restart from DONE.
    cyc(1, 0, 0, 0);
    chk("t5_done0", 32'(done), 32'h1);
    chk("t5_sig0", 32'(sig), 32'h0);
    chk("t5_cnt0", 32'(vec_cnt), 32'h0);
    chk("t5_busy0", 32'(busy), 32'h0);
    cyc(1, 3, 0, 0);
    chk("t5_busy", 32'(busy), 32'h1);
    cyc(0, 0, 1, 24'h000001);
    cyc(1, 1, 1, 24'h000002);
    chk("t5_ign_sig", 32'(sig), 32'h000000);
    chk("t5_ign_cnt", 32'(vec_cnt), 32'h2);
    chk("t5_ign_busy", 32'(busy), 32'h1);
    cyc(0, 0, 1, 24'h000004);
    chk("t5_sig", 32'(sig), 32'h000004);
    chk("t5_done", 32'(done), 32'h1);
    cyc(1, 1, 0, 0);
    chk("t5_reseed", 32'(sig), 32'h0);
    chk("t5_recnt", 32'(vec_cnt), 32'h0);
    cyc(0, 0, 1, 24'h000007);
    chk("t5_rerun", 32'(sig), 32'h000007);

    // Asynchronous reset mid-cycle during a run.
    cyc(1, 5, 0, 0);
    cyc(0, 0, 1, 24'h123456);
    #3 RST = 1'b1;
    #1;
    chk("t1_sig", 32'(sig), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_done", 32'(done), 32'h0);
    chk("t1_pass", 32'(pass), 32'h0);
    @(negedge CK);
    RST = 1'b0;
    cyc(0, 0, 0, 0);

    // Random run aborted by reset after 500 vectors, then a full 500 run.
    cyc(1, 16'd600, 0, 0);
    acc = 0;
    while (acc < 500) begin
      if ($urandom_range(3) != 0) begin
        cyc(0, 0, 1, 24'($urandom));
        acc++;
      end else begin
        cyc(0, 0, 0, 24'($urandom));
      end
    end
    chk("t6_mid_cnt", 32'(vec_cnt), 32'd500);
    RST = 1'b1;
    @(negedge CK);
    chk("t6_rst_sig", 32'(sig), 32'(SEED));
    chk("t6_rst_busy", 32'(busy), 32'h0);
    RST = 1'b0;
    cyc(1, 16'd500, 0, 0);
    acc = 0;
    while (acc < 500) begin
      if ($urandom_range(3) != 0) begin
        cyc(0, 0, 1, 24'($urandom));
        acc++;
      end else begin
        cyc(0, 0, 0, 24'($urandom));
      end
    end
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_cnt", 32'(vec_cnt), 32'd500);
    golden = m_sig; #1;
    chk("t6_pass", 32'(pass), 32'h1);
    cyc(0, 0, 1, 24'hABCDEF);
    chk("t6_hold", 32'(sig), 32'(golden));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
